data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data port. It accepts load/store requests on an SRAM-like req/addr_ok/data_ok handshake.
- Requests are queued in order, held for a fixed latency, then committed or returned.
- Load data goes back as a full aligned word; byte/half/lwl/lwr extraction stays in the memory stage. Stores merge per-byte strobes, which covers sb/sh/sw/swl/swr.
- Used as the data memory in simulation/SoC-lite builds and as the target for CPU stall testing.

Parameters:
- ADDR_W, 12, word-index width; memory holds 2^ADDR_W 32-bit words.
- LATENCY, 1, cycles from handshake to data_ok, legal range 1..8.
- QDEPTH, 2, request queue entries, power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- data_sram_req  in  1  request valid
- data_sram_wr  in  1  1 = store, 0 = load
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word; recorded only, does not affect behaviour
- data_sram_addr  in  32  byte address; addr[ADDR_W+1:2] selects the word
- data_sram_wstrb  in  4  byte write enables for stores, bit i = byte i
- data_sram_wdata  in  32  store data, already lane-aligned
- data_sram_addr_ok  out  1  request accepted this cycle when req is also high
- data_sram_data_ok  out  1  one-cycle response pulse, in request order
- data_sram_rdata  out  32  load word, valid only with data_ok

Behaviour:
- One clock: clk. Reset: asynchronous, active-high, on port reset.
- Reset clears the queue, count, head timer and pointers immediately, without waiting for a clock edge.
  - Outputs after reset: addr_ok=1, data_ok=0, rdata=0.
  - Memory array contents are not cleared.
  - If reset arrives mid-operation, all pending entries are dropped, uncommitted stores are never written, and no data_ok is issued for them.
- Handshake:
  - addr_ok = !full, where full means count==QDEPTH. It is combinational from the count and never depends on req.
  - A request is accepted in a cycle with req && addr_ok. At that clock edge {wr, size, addr, wstrb, wdata} are written into the queue tail.
  - The requester may drop or change req freely when addr_ok is low.
- Queue:
  - Circular FIFO with head and tail pointers and count.
  - Pointers wrap modulo QDEPTH.
  - Accept and retire in the same cycle leave count unchanged.
  - A full queue rejects new requests even when the head retires in that cycle; addr_ok uses the current count only.
- Head timer, 3-bit down-counter:
  - Loaded with LATENCY-1 at every edge where a new entry becomes head. That happens in two cases: an accept into an empty queue (or into a queue whose only entry retires that same edge), or a retire with a non-empty remainder.
  - Otherwise the timer decrements while nonzero.
- Response:
  - data_ok = head_valid && timer==0, combinational, high for exactly one cycle per entry.
  - The head retires at the edge ending the data_ok cycle.
- Timing:
  - For a request accepted in cycle N into an empty queue, data_ok is in cycle N+LATENCY.
  - Later entries respond LATENCY cycles after the previous retire.
  - With LATENCY=1, throughput is one response per cycle.
- Loads: rdata = mem[head.addr[ADDR_W+1:2]] during data_ok, and 0 otherwise.
- Stores:
  - At the edge ending their data_ok cycle, byte i of the word is written with wdata byte i for each set wstrb[i].
  - wstrb=0 writes nothing but still produces data_ok.
  - rdata is 0 for a store response.
- Ordering:
  - Stores commit only at retire.
  - A load queued behind a store to the same word observes the merged value.
  - No forwarding is needed, because responses are strictly in order.
- Address bits above ADDR_W+1 are ignored (aliasing). addr[1:0] is ignored for array indexing.

Test Plan:
- Reset behaviour: assert reset asynchronously between edges while 2 entries are pending -> addr_ok=1, data_ok=0 and rdata=0 at once; after release, no stale data_ok appears and the dropped store's target word is unchanged.
- Basic latency, LATENCY=1: store word 0x11223344 to 0x100 (wstrb=F), then load 0x100 -> data_ok for the store is 1 cycle after accept; the load returns rdata=0x11223344 one cycle after its own accept.
- Partial strobes: word at 0x200 = 0xAABBCCDD; store wstrb=0011 with wdata=0x00001234 (swr-style), then load -> 0xAABB1234. Then store wstrb=1000 with wdata=0x77000000 and load -> 0x77BB1234.
- Queue full, LATENCY=4, QDEPTH=2: hold req high for 4 cycles -> addr_ok is high for 2 accepts, low until the first data_ok (4 cycles after the first accept), and accepts resume the cycle after that; responses arrive 4 cycles apart.
- Ordering: store 0xDEADBEEF to 0x40 immediately followed by a load of 0x40 while the store is still queued -> load rdata=0xDEADBEEF, and the two data_ok pulses come in request order.
- Aliasing and zero strobe: store with wstrb=0 to 0x300 -> data_ok is issued and a later load is unchanged. A load at addr (1<<(ADDR_W+2))+0x300 returns the same word as 0x300.

Source files
------------

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - in-order fixed-latency SRAM-handshake data memory responder
module data_sram_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1,
    parameter int QDEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [2:0] T_LOAD = 3'(LATENCY - 1);
    localparam logic [PW:0] Q_FULL = QDEPTH[PW:0];

    logic [31:0]       mem [2**ADDR_W];

    logic              q_wr    [QDEPTH];
    logic [1:0]        q_size  [QDEPTH];
    logic [ADDR_W-1:0] q_addr  [QDEPTH];
    logic [3:0]        q_wstrb [QDEPTH];
    logic [31:0]       q_wdata [QDEPTH];

    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic [2:0]    timer;
    logic          accept, retire, head_valid, load_timer;
    logic          unused_bits;

    assign data_sram_addr_ok = (count != Q_FULL);
    assign head_valid        = (count != '0);
    assign data_sram_data_ok = head_valid && (timer == 3'd0);
    assign accept            = data_sram_req && data_sram_addr_ok;
    assign retire            = data_sram_data_ok;

    // A new head appears either from an accept into an (effectively) empty
    // queue or from a retire that leaves entries behind.
    assign load_timer = (accept && ((count == '0) || ((count == 1) && retire)))
                      || (retire && (count > 1));

    assign data_sram_rdata = (data_sram_data_ok && !q_wr[head]) ? mem[q_addr[head]] : 32'd0;

    assign unused_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0], q_size[head]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            timer <= 3'd0;
        end else begin
            if (accept) tail <= tail + 1'b1;
            if (retire) head <= head + 1'b1;
            if (accept && !retire)
                count <= count + 1'b1;
            else if (retire && !accept)
                count <= count - 1'b1;
            if (load_timer)
                timer <= T_LOAD;
            else if (timer != 3'd0)
                timer <= timer - 3'd1;
        end
    end

    // Payload and array carry no reset; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_wr[tail]    <= data_sram_wr;
            q_size[tail]  <= data_sram_size;
            q_addr[tail]  <= data_sram_addr[ADDR_W+1:2];
            q_wstrb[tail] <= data_sram_wstrb;
            q_wdata[tail] <= data_sram_wdata;
        end
        if (retire && q_wr[head]) begin
            for (int b = 0; b < 4; b++) begin
                if (q_wstrb[head][b])
                    mem[q_addr[head]][8*b +: 8] <= q_wdata[head][8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - bench for data_sram_responder at LATENCY 1 and 4
module tb_data_sram_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req1, wr1, aok1, dok1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  wstrb1;
    logic        req4, wr4, aok4, dok4;
    logic [31:0] addr4, wdata4, rdata4;
    logic [3:0]  wstrb4;

    data_sram_responder #(.ADDR_W(12), .LATENCY(1), .QDEPTH(2)) dut1 (
        .clk(clk), .reset(reset),
        .data_sram_req(req1), .data_sram_wr(wr1), .data_sram_size(2'd2),
        .data_sram_addr(addr1), .data_sram_wstrb(wstrb1), .data_sram_wdata(wdata1),
        .data_sram_addr_ok(aok1), .data_sram_data_ok(dok1), .data_sram_rdata(rdata1)
    );

    data_sram_responder #(.ADDR_W(12), .LATENCY(4), .QDEPTH(2)) dut4 (
        .clk(clk), .reset(reset),
        .data_sram_req(req4), .data_sram_wr(wr4), .data_sram_size(2'd2),
        .data_sram_addr(addr4), .data_sram_wstrb(wstrb4), .data_sram_wdata(wdata4),
        .data_sram_addr_ok(aok4), .data_sram_data_ok(dok4), .data_sram_rdata(rdata4)
    );

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt [16];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [13:0] exp_aok;
        logic [13:0] exp_dok;
        int lat;

        // One record per cycle; outputs belong to the request of the previous cycle.
        vt[0]  = '{1'b1, 1'b1, 32'h100,  4'hF, 32'h11223344, 1'b1, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 32'h100,  4'h0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[2]  = '{1'b1, 1'b1, 32'h200,  4'hF, 32'hAABBCCDD, 1'b1, 1'b1, 32'h11223344};
        vt[3]  = '{1'b1, 1'b1, 32'h200,  4'h3, 32'h00001234, 1'b1, 1'b1, 32'h0};
        vt[4]  = '{1'b1, 1'b0, 32'h200,  4'h0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[5]  = '{1'b1, 1'b1, 32'h200,  4'h8, 32'h77000000, 1'b1, 1'b1, 32'hAABB1234};
        vt[6]  = '{1'b1, 1'b0, 32'h200,  4'h0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[7]  = '{1'b1, 1'b1, 32'h40,   4'hF, 32'hDEADBEEF, 1'b1, 1'b1, 32'h77BB1234};
        vt[8]  = '{1'b1, 1'b0, 32'h40,   4'h0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[9]  = '{1'b1, 1'b1, 32'h300,  4'hF, 32'h5A5A0F0F, 1'b1, 1'b1, 32'hDEADBEEF};
        vt[10] = '{1'b1, 1'b1, 32'h300,  4'h0, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0};
        vt[11] = '{1'b1, 1'b0, 32'h300,  4'h0, 32'h0,        1'b1, 1'b1, 32'h0};
        vt[12] = '{1'b1, 1'b0, 32'h4300, 4'h0, 32'h0,        1'b1, 1'b1, 32'h5A5A0F0F};
        vt[13] = '{1'b1, 1'b0, 32'h103,  4'h0, 32'h0,        1'b1, 1'b1, 32'h5A5A0F0F};
        vt[14] = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b1, 32'h11223344};
        vt[15] = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b0, 32'h0};

        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wstrb1 = '0; wdata1 = '0;
        req4 = 1'b0; wr4 = 1'b0; addr4 = '0; wstrb4 = '0; wdata4 = '0;

        repeat (3) step();
        check("rst aok1", 32'(aok1), 32'd1);
        check("rst dok1", 32'(dok1), 32'd0);
        check("rst rdata1", rdata1, 32'd0);
        check("rst aok4", 32'(aok4), 32'd1);
        check("rst dok4", 32'(dok4), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req1 = vt[i].req; wr1 = vt[i].wr; addr1 = vt[i].addr;
            wstrb1 = vt[i].wstrb; wdata1 = vt[i].wdata;
            #1;
            check($sformatf("v%0d aok", i), 32'(aok1), 32'(vt[i].aok));
            check($sformatf("v%0d dok", i), 32'(dok1), 32'(vt[i].dok));
            check($sformatf("v%0d rdata", i), rdata1, vt[i].rdata);
            step();
        end

        // Queue full at LATENCY 4: store then two loads of the same word, req held c0..c5.
        exp_aok = 14'b11111000100011;
        exp_dok = 14'b01000100010000;
        req4 = 1'b1; wr4 = 1'b1; addr4 = 32'h40; wstrb4 = 4'hF; wdata4 = 32'hDEADBEEF;
        #1;
        check("full c0 aok", 32'(aok4), 32'd1);
        step();
        wr4 = 1'b0; wstrb4 = 4'h0;
        #1;
        check("full c1 aok", 32'(aok4), 32'd1);
        check("full c1 dok", 32'(dok4), 32'd0);
        step();
        for (int c = 2; c <= 13; c++) begin
            if (c == 6) req4 = 1'b0;
            #1;
            check($sformatf("full c%0d aok", c), 32'(aok4), 32'(exp_aok[c]));
            check($sformatf("full c%0d dok", c), 32'(dok4), 32'(exp_dok[c]));
            check($sformatf("full c%0d rdata", c), rdata4,
                  (c == 8 || c == 12) ? 32'hDEADBEEF : 32'h0);
            step();
        end

        // Asynchronous reset with a store and a load pending.
        req4 = 1'b1; wr4 = 1'b1; addr4 = 32'h40; wstrb4 = 4'hF; wdata4 = 32'h12345678;
        step();
        wr4 = 1'b0; wstrb4 = 4'h0;
        step();
        req4 = 1'b0;
        #1;
        check("pre-rst aok4", 32'(aok4), 32'd0);
        #1 reset = 1'b1;
        #1;
        check("mid-rst aok4", 32'(aok4), 32'd1);
        check("mid-rst dok4", 32'(dok4), 32'd0);
        check("mid-rst rdata4", rdata4, 32'd0);
        step();
        #3 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("post-rst dok4 %0d", k), 32'(dok4), 32'd0);
        end

        req4 = 1'b1; wr4 = 1'b0; addr4 = 32'h40;
        step();
        req4 = 1'b0;
        lat = 1;
        while (!dok4 && lat < 12) begin
            step();
            lat++;
        end
        check("post-rst load dok", 32'(dok4), 32'd1);
        check("post-rst load latency", 32'(lat), 32'd4);
        check("post-rst load rdata", rdata4, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
